count_seg_display: RTL and testbench

Downstream display stage for the up/down counter pair. Takes the two 4-bit count values (`count_a` up-count, `count_b` down-count), converts each to two decimal digits, and drives a 4-digit time-multiplexed seven-segment display. Inputs are captured once per scan frame, so a displayed frame never mixes old and new counts. Sits between the counter block and the board display pins.

---
 rtl/count_seg_display.sv | 133 +++++++++++++
 tb/tb_count_seg_display.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/count_seg_display.sv
// Time-multiplexed 4-digit seven-segment driver for two 4-bit counts.
// Each count is snapshotted once per scan frame and shown as two decimal digits.
module count_seg_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] count_a,
    input  logic [3:0] count_b,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    // Inactive output levels depend on the display polarity.
    localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = COMMON_ANODE;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       snap_a_q, snap_b_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick, load;

    logic [3:0] digit_val;
    logic       digit_blank;
    logic       digit_dp;
    logic [6:0] seg_ah;
    logic [3:0] an_ah;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [3:0] v);
        bcd_ones = (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

    always_comb begin
        tick  = enable && (pre_q == PRE_MAX);
        load  = enable && (pre_q == '0) && (idx_q == 2'd0);
        pre_d = pre_q;
        idx_d = idx_q;
        if (tick) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end else if (enable) begin
            pre_d = pre_q + PRE_ONE;
        end
    end

    // Tens digits are only ever 0 or 1 for a 4-bit value; 0 is blanked.
    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b0;
        digit_dp    = 1'b0;
        case (idx_q)
            2'd0: digit_val = bcd_ones(snap_a_q);
            2'd1: begin
                digit_val   = 4'd1;
                digit_blank = (snap_a_q < 4'd10);
            end
            2'd2: begin
                digit_val = bcd_ones(snap_b_q);
                digit_dp  = 1'b1;
            end
            default: begin
                digit_val   = 4'd1;
                digit_blank = (snap_b_q < 4'd10);
            end
        endcase
        seg_ah = digit_blank ? 7'h00 : seg_code(digit_val);
        an_ah  = 4'b0001 << idx_q;

        if (enable) begin
            an_d  = COMMON_ANODE ? ~an_ah  : an_ah;
            seg_d = COMMON_ANODE ? ~seg_ah : seg_ah;
            dp_d  = COMMON_ANODE ? ~digit_dp : digit_dp;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q    <= '0;
            idx_q    <= 2'd0;
            snap_a_q <= 4'd0;
            snap_b_q <= 4'd0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            if (load) begin
                snap_a_q <= count_a;
                snap_b_q <= count_b;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Scoreboard bench for count_seg_display (REFRESH_DIV = 4, common anode).
// Expected {an,seg,dp} is queued before each edge and compared just after it.
module tb_count_seg_display;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] count_a;
    logic [3:0] count_b;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int m_pre, m_idx, m_sa, m_sb;
    logic [11:0] exp_q[$];

    count_seg_display #(.REFRESH_DIV(R), .COMMON_ANODE(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .count_a (count_a),
        .count_b (count_b),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                     tag, cyc, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    function automatic logic [6:0] seg_ah(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference: output after this edge comes from the state before it.
    task automatic step(input string tag);
        logic [11:0] e, got;
        logic [3:0]  a_ah;
        logic [6:0]  s_ah;
        logic        d_ah;
        int          v;
        if (!rst) begin
            e = 12'hFFF;
            m_pre = 0; m_idx = 0; m_sa = 0; m_sb = 0;
        end else if (!enable) begin
            e = 12'hFFF;
        end else begin
            v = (m_idx < 2) ? m_sa : m_sb;
            if (m_idx % 2 == 0) s_ah = seg_ah(v % 10);
            else                s_ah = (v / 10 == 0) ? 7'h00 : seg_ah(v / 10);
            d_ah = (m_idx == 2);
            a_ah = 4'b0001 << m_idx;
            e = ~{a_ah, s_ah, d_ah};
            if (m_pre == 0 && m_idx == 0) begin
                m_sa = int'(count_a);
                m_sb = int'(count_b);
            end
            if (m_pre == R - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = {an, seg, dp};
        e = exp_q.pop_front();
        $display("cyc %0d %s rst=%b en=%b a=%0d b=%0d an=%b seg=%h dp=%b",
                 cyc, tag, rst, enable, count_a, count_b, an, seg, dp);
        check_eq(tag, got, e);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic run_until(input string tag, input int idx, input int pre);
        for (int i = 0; i < 4 * R + 2 && !(m_idx == idx && m_pre == pre); i++) step(tag);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; count_a = 4'd0; count_b = 4'd0;
        m_pre = 0; m_idx = 0; m_sa = 0; m_sb = 0;

        // Reset held with enable high: outputs stay inactive.
        run("reset", 3);
        check_eq("reset_const", {an, seg, dp}, 12'hFFF);

        rst = 1'b1; count_a = 4'd12; count_b = 4'd7;
        run("scan_12_7", 20);

        // Input change mid-frame waits for the next frame.
        run_until("to_dig1", 1, 1);
        count_a = 4'd3;
        run("chg_a_3", 20);

        // Freeze partway through digit 1's dwell.
        run_until("to_dig1b", 1, 2);
        enable = 1'b0;
        run("disabled", 10);
        enable = 1'b1;
        run("resume", 12);

        count_a = 4'd15; count_b = 4'd0;
        run("bound_15_0", 20);
        count_a = 4'd9; count_b = 4'd10;
        run("bound_9_10", 20);

        // Reset pulse during digit 2.
        run_until("to_dig2", 2, 1);
        rst = 1'b0;
        run("mid_reset", 1);
        rst = 1'b1;
        run("after_reset", 20);

        for (int i = 0; i < 120; i++) begin
            count_a = 4'($urandom_range(0, 15));
            count_b = 4'($urandom_range(0, 15));
            enable  = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 40) != 0);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
